// File: rtl/trace_pkg.sv
// Trace FIFO word format shared by the capture stage and the read-side unpacker.
// A word is {tag, payload}: tag 0 carries a sample, tag 1 carries a drop count in the payload LSBs.
package trace_pkg;

    localparam int   TRACE_SAMPLE_W = 16;
    localparam int   TRACE_TAG_POS  = TRACE_SAMPLE_W;
    localparam logic TAG_SAMPLE     = 1'b0;
    localparam logic TAG_LOSS       = 1'b1;

    typedef struct packed {
        logic                      is_loss;
        logic [TRACE_SAMPLE_W-1:0] payload;
    } trace_word_t;

endpackage

// File: rtl/trace_sat_add.sv
// Unsigned adder that clamps to all-ones on carry-out and flags the clamp.
module trace_sat_add #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] sum_o,
    output logic               sat_o
);

    logic [width_p:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o    = full_sum[width_p];
    assign sum_o    = sat_o ? {width_p{1'b1}} : full_sum[width_p-1:0];

endmodule

// File: rtl/trace_unpacker.sv
// Read side of the trace backpressure FIFO: re-emits samples on a valid/ready stream,
// tags the first sample after a loss gap with the merged drop count, keeps sticky loss stats.
module trace_unpacker
    import trace_pkg::*;
#(
    parameter int sample_width_p  = 16,
    parameter int counter_width_p = 16,
    parameter int total_width_p   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [sample_width_p:0]    fifo_data,
    input  logic                       fifo_valid,
    output logic                       fifo_ready,
    output logic [sample_width_p-1:0]  sample_o,
    output logic                       sample_v_o,
    input  logic                       sample_ready_i,
    output logic                       gap_v_o,
    output logic [counter_width_p-1:0] gap_count_o,
    output logic                       gap_sat_o,
    output logic [total_width_p-1:0]   total_lost_o,
    output logic                       lost_sat_o,
    output logic                       proto_err_o,
    input  logic                       clear_i
);

    logic                       ready_en_q,  ready_en_d;
    logic                       sample_v_q,  sample_v_d;
    logic [sample_width_p-1:0]  sample_q,    sample_d;
    logic                       gap_v_q,     gap_v_d;
    logic [counter_width_p-1:0] gap_count_q, gap_count_d;
    logic                       gap_sat_q,   gap_sat_d;
    logic                       pend_q,      pend_d;
    logic [counter_width_p-1:0] pend_cnt_q,  pend_cnt_d;
    logic                       pend_sat_q,  pend_sat_d;
    logic [total_width_p-1:0]   total_q,     total_d;
    logic                       lost_sat_q,  lost_sat_d;
    logic                       perr_q,      perr_d;

    logic                       tag;
    logic [sample_width_p-1:0]  payload;
    logic [counter_width_p-1:0] cnt;
    logic [total_width_p-1:0]   cnt_ext;
    logic [total_width_p-1:0]   total_base;
    logic                       pop, malformed, cnt_max;
    logic                       sample_pop, loss_ok, loss_bad;
    logic [counter_width_p-1:0] pend_sum;
    logic                       pend_add_sat;
    logic [total_width_p-1:0]   total_sum;
    logic                       total_add_sat;

    // Valid/ready: a word (either tag) moves when fifo_valid & fifo_ready at a posedge;
    // the output register holds until sample_v_o & sample_ready_i.
    assign fifo_ready = ready_en_q & (~sample_v_q | sample_ready_i);
    assign pop        = fifo_valid & fifo_ready;

    assign tag     = fifo_data[sample_width_p];
    assign payload = fifo_data[sample_width_p-1:0];
    assign cnt     = payload[counter_width_p-1:0];
    assign cnt_max = &cnt;

    assign malformed  = (cnt == '0) | ((payload >> counter_width_p) != '0);
    assign sample_pop = pop & (tag == TAG_SAMPLE);
    assign loss_ok    = pop & (tag == TAG_LOSS) & ~malformed;
    assign loss_bad   = pop & (tag == TAG_LOSS) & malformed;

    always_comb begin
        cnt_ext                      = '0;
        cnt_ext[counter_width_p-1:0] = cnt;
    end

    // A clear on the same edge as a loss pop zeroes the stats first, then the pop accumulates.
    assign total_base = clear_i ? '0 : total_q;

    trace_sat_add #(.width_p(counter_width_p)) u_pend_add (
        .a_i   (pend_cnt_q),
        .b_i   (cnt),
        .sum_o (pend_sum),
        .sat_o (pend_add_sat)
    );

    trace_sat_add #(.width_p(total_width_p)) u_total_add (
        .a_i   (total_base),
        .b_i   (cnt_ext),
        .sum_o (total_sum),
        .sat_o (total_add_sat)
    );

    always_comb begin
        ready_en_d  = 1'b1;
        sample_v_d  = sample_v_q;
        sample_d    = sample_q;
        gap_v_d     = gap_v_q;
        gap_count_d = gap_count_q;
        gap_sat_d   = gap_sat_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        pend_sat_d  = pend_sat_q;
        total_d     = total_base;
        lost_sat_d  = clear_i ? 1'b0 : lost_sat_q;
        perr_d      = clear_i ? 1'b0 : perr_q;

        if (sample_pop) begin
            sample_v_d  = 1'b1;
            sample_d    = payload;
            gap_v_d     = pend_q;
            gap_count_d = pend_cnt_q;
            gap_sat_d   = pend_sat_q;
            pend_d      = 1'b0;
            pend_cnt_d  = '0;
            pend_sat_d  = 1'b0;
        end else if (sample_v_q & sample_ready_i) begin
            sample_v_d = 1'b0;
        end

        if (loss_ok) begin
            pend_d     = 1'b1;
            pend_cnt_d = pend_sum;
            pend_sat_d = pend_sat_q | cnt_max | pend_add_sat;
            total_d    = total_sum;
            lost_sat_d = lost_sat_d | cnt_max | pend_add_sat | total_add_sat;
        end

        if (loss_bad) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            sample_v_q  <= 1'b0;
            sample_q    <= '0;
            gap_v_q     <= 1'b0;
            gap_count_q <= '0;
            gap_sat_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
            pend_sat_q  <= 1'b0;
            total_q     <= '0;
            lost_sat_q  <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            ready_en_q  <= ready_en_d;
            sample_v_q  <= sample_v_d;
            sample_q    <= sample_d;
            gap_v_q     <= gap_v_d;
            gap_count_q <= gap_count_d;
            gap_sat_q   <= gap_sat_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_sat_q  <= pend_sat_d;
            total_q     <= total_d;
            lost_sat_q  <= lost_sat_d;
            perr_q      <= perr_d;
        end
    end

    assign sample_o     = sample_q;
    assign sample_v_o   = sample_v_q;
    assign gap_v_o      = gap_v_q;
    assign gap_count_o  = gap_count_q;
    assign gap_sat_o    = gap_sat_q;
    assign total_lost_o = total_q;
    assign lost_sat_o   = lost_sat_q;
    assign proto_err_o  = perr_q;

endmodule

// File: tb/tb_trace_unpacker.sv
// Scoreboarded bench for trace_unpacker: FIFO model drives words, a reference model of the
// gap/loss rules predicts outputs, and a negedge monitor compares whatever the DUT presents.
module tb_trace_unpacker;

    localparam int SW = 16;
    localparam int CW = 16;
    localparam int TW = 32;
    localparam int EW = SW + 1 + CW + 1;
    localparam longint TOTAL_MAX = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [SW:0]   fifo_data = '0;
    logic          fifo_valid = 1'b0;
    logic          fifo_ready;
    logic [SW-1:0] sample_o;
    logic          sample_v_o;
    logic          sample_ready_i = 1'b0;
    logic          gap_v_o;
    logic [CW-1:0] gap_count_o;
    logic          gap_sat_o;
    logic [TW-1:0] total_lost_o;
    logic          lost_sat_o;
    logic          proto_err_o;
    logic          clear_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [SW:0]   fifo_q[$];

    // Reference model: exact (unbounded) sums, clamped only when producing expectations.
    bit     gap_pend = 0;
    longint gap_sum = 0;
    bit     gap_seen_max = 0;
    longint total_exact = 0;
    bit     m_lost_sat = 0;
    bit     m_perr = 0;

    trace_unpacker #(
        .sample_width_p  (SW),
        .counter_width_p (CW),
        .total_width_p   (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_data      (fifo_data),
        .fifo_valid     (fifo_valid),
        .fifo_ready     (fifo_ready),
        .sample_o       (sample_o),
        .sample_v_o     (sample_v_o),
        .sample_ready_i (sample_ready_i),
        .gap_v_o        (gap_v_o),
        .gap_count_o    (gap_count_o),
        .gap_sat_o      (gap_sat_o),
        .total_lost_o   (total_lost_o),
        .lost_sat_o     (lost_sat_o),
        .proto_err_o    (proto_err_o),
        .clear_i        (clear_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_total();
        return (total_exact > TOTAL_MAX) ? TOTAL_MAX : total_exact;
    endfunction

    function automatic logic m_lost_sat_eff();
        return m_lost_sat || (total_exact > TOTAL_MAX);
    endfunction

    task automatic model_clear_all();
        exp_q.delete();
        gap_pend     = 0;
        gap_sum      = 0;
        gap_seen_max = 0;
        total_exact  = 0;
        m_lost_sat   = 0;
        m_perr       = 0;
    endtask

    task automatic model_pop(input logic [SW:0] w);
        logic [CW-1:0] c;
        logic [SW-1:0] pl;
        logic [CW-1:0] gc;
        logic          gs;
        pl = w[SW-1:0];
        c  = pl[CW-1:0];
        if (w[SW]) begin
            if (c == 0 || (pl >> CW) != 0) begin
                m_perr = 1;
            end else begin
                gap_pend = 1;
                gap_sum += longint'(c);
                if (c == 16'hFFFF) gap_seen_max = 1;
                total_exact += longint'(c);
                if (c == 16'hFFFF || gap_sum > 64'hFFFF) m_lost_sat = 1;
            end
        end else begin
            gc = gap_pend ? ((gap_sum > 64'hFFFF) ? 16'hFFFF : gap_sum[CW-1:0]) : '0;
            gs = gap_pend && (gap_seen_max || gap_sum > 64'hFFFF);
            exp_q.push_back({pl, gap_pend, gc, gs});
            gap_pend     = 0;
            gap_sum      = 0;
            gap_seen_max = 0;
        end
    endtask

    task automatic drive_fifo();
        fifo_valid = (fifo_q.size() > 0);
        fifo_data  = fifo_valid ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [SW:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: handshakes are sampled at the negedge, applied to the models after the posedge.
    task automatic step();
        bit          pop;
        bit          clr;
        logic [SW:0] w;
        @(negedge clk);
        pop = fifo_valid && fifo_ready;
        clr = clear_i;
        w   = fifo_data;
        @(posedge clk);
        #1;
        if (clr) begin
            total_exact = 0;
            m_lost_sat  = 0;
            m_perr      = 0;
        end
        if (pop) begin
            void'(fifo_q.pop_front());
            model_pop(w);
        end
        clear_i = 1'b0;
        drive_fifo();
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 0;
        sample_ready_i = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !sample_v_o) begin
                done = 1;
                break;
            end
            step();
        end
        if (!done) done = (fifo_q.size() == 0 && exp_q.size() == 0 && !sample_v_o);
        chk("drain_complete", 64'(done), 64'd1);
    endtask

    // Called just after a posedge; asserts reset asynchronously mid-cycle.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        model_clear_all();
        chk("rst_sample_v", 64'(sample_v_o), 64'd0);
        chk("rst_fifo_ready", 64'(fifo_ready), 64'd0);
        chk("rst_outputs", {sample_o, gap_v_o, gap_count_o, gap_sat_o}, 64'd0);
        chk("rst_stats", {total_lost_o, lost_sat_o, proto_err_o}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rel_fifo_ready_before_edge", 64'(fifo_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_fifo_ready_after_edge1", 64'(fifo_ready), 64'd1);
        chk("rel_no_pop_edge1", 64'(sample_v_o), 64'd0);
        drive_fifo();
    endtask

    function automatic logic [SW:0] rand_word();
        int r;
        logic [CW-1:0] c;
        r = $urandom_range(0, 99);
        if (r < 65) return {1'b0, 16'($urandom)};
        r = $urandom_range(0, 9);
        if (r == 0)     c = '0;
        else if (r < 2) c = 16'hFFFF;
        else if (r < 6) c = 16'($urandom_range(1, 20));
        else            c = 16'($urandom_range(1, 65535));
        return {1'b1, c};
    endfunction

    // Monitor: compares stats every cycle and the presented sample against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("total_lost", 64'(total_lost_o), m_total());
            chk("lost_sat", 64'(lost_sat_o), 64'(m_lost_sat_eff()));
            chk("proto_err", 64'(proto_err_o), 64'(m_perr));
            if (sample_v_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_unexpected: got 0x%0h expected none at %0t", sample_o, $time);
                end else begin
                    chk("sample", 64'({sample_o, gap_v_o, gap_count_o, gap_sat_o}), 64'(exp_q[0]));
                    if (sample_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();

        // Plain samples, back-to-back.
        sample_ready_i = 1'b1;
        push_word(17'h0_1234);
        push_word(17'h0_5678);
        push_word(17'h0_9ABC);
        push_word(17'h0_DEF0);
        repeat (4) step();
        chk("t2_throughput_fifo_empty", 64'(fifo_q.size()), 64'd0);
        drain(50);
        chk("t2_total", 64'(total_lost_o), 64'd0);

        // Single loss then sample.
        push_word(17'h1_0003);
        push_word(17'h0_00AA);
        drain(50);
        chk("t3_total", 64'(total_lost_o), 64'd3);

        // Saturating gap merge.
        clear_i = 1'b1;
        step();
        push_word(17'h1_FFFF);
        push_word(17'h1_0002);
        push_word(17'h0_0001);
        drain(50);
        chk("t4_total", 64'(total_lost_o), 64'h0001_0001);
        chk("t4_lost_sat", 64'(lost_sat_o), 64'd1);

        // Backpressure with a full FIFO.
        sample_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push_word({1'b0, 16'(16'h0100 + i)});
        repeat (5) step();
        chk("t5_single_pop", 64'(fifo_q.size()), 64'd5);
        chk("t5_ready_low", 64'(fifo_ready), 64'd0);
        sample_ready_i = 1'b1;
        repeat (5) step();
        chk("t5_drain_rate", 64'(fifo_q.size()), 64'd0);
        drain(50);

        // Malformed packet, then clear coinciding with a loss pop.
        push_word(17'h1_0000);
        drain(50);
        chk("t6_proto_err", 64'(proto_err_o), 64'd1);
        chk("t6_total_unchanged", 64'(total_lost_o), 64'h0001_0001);
        push_word(17'h1_0004);
        clear_i = 1'b1;
        step();
        chk("t6_clear_proto_err", 64'(proto_err_o), 64'd0);
        chk("t6_clear_total", 64'(total_lost_o), 64'd4);

        // Reset in the middle of traffic (pending gap of 4 is discarded).
        for (int i = 0; i < 6; i++) push_word({1'b0, 16'(16'h0200 + i)});
        sample_ready_i = 1'b0;
        repeat (3) step();
        reset_dut();
        drain(50);

        // Randomized traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            sample_ready_i = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) push_word(rand_word());
            clear_i = ($urandom_range(0, 39) == 0);
            step();
            if (cyc == 700) reset_dut();
        end
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
